// File: rtl/pio_key_dbnc_pkg.sv
// Shared constants for the key PIO: register word addresses, edge-type selectors
// and a constant clog2 used to size the debounce counters.
package pio_key_pkg;

  typedef enum logic [1:0] {
    ADDR_DATA = 2'd0,
    ADDR_RAW  = 2'd1,
    ADDR_MASK = 2'd2,
    ADDR_EDGE = 2'd3
  } pio_addr_e;

  localparam int unsigned EDGE_FALL = 0;
  localparam int unsigned EDGE_RISE = 1;
  localparam int unsigned EDGE_ANY  = 2;

  // Bits needed to hold 0..v-1; never less than 1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if (((v - 1) >> i) != 0) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pio_key_dbnc_debounce.sv
// One key channel: 2-flop synchroniser followed by a counter debouncer.
// Reset state is "released" (all ones) so no edge is seen coming out of reset.
module key_debounce
  import pio_key_pkg::*;
#(
  parameter int unsigned DBNC_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic key_in,
  output logic sync_out,
  output logic dbnc_out
);

  localparam int unsigned   CW   = clog2(DBNC_CYCLES);
  localparam logic [CW-1:0] TERM = CW'(DBNC_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          dbnc;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      dbnc  <= 1'b1;
      cnt   <= '0;
    end else begin
      sync1 <= key_in;
      sync2 <= sync1;
      // Any sample matching the debounced value restarts the stability count.
      if (sync2 == dbnc) begin
        cnt <= '0;
      end else if (cnt == TERM) begin
        dbnc <= sync2;
        cnt  <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign sync_out = sync2;
  assign dbnc_out = dbnc;

endmodule

// File: rtl/pio_key_dbnc.sv
// Multi-channel debounced key PIO, Avalon-MM slave with edge capture and level IRQ.
// Build option PIO_KEY_BITCLR_EN: edge_capture writes are write-1-to-clear instead of clear-all.
module pio_key_dbnc
  import pio_key_pkg::*;
#(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned DBNC_CYCLES = 1000000,
  parameter int unsigned EDGE_TYPE   = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] dbnc;
  logic [WIDTH-1:0] dbnc_d;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_capture;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] clr_bits;
  logic [31:0]      rd_next;
  logic             wr_en;

  for (genvar g = 0; g < WIDTH; g++) begin : g_key
    key_debounce #(
      .DBNC_CYCLES(DBNC_CYCLES)
    ) u_key (
      .clk     (clk),
      .reset   (reset),
      .key_in  (in_port[g]),
      .sync_out(sync2[g]),
      .dbnc_out(dbnc[g])
    );
  end

  if (WIDTH < 32) begin : g_unused
    logic unused_wd;
    assign unused_wd = ^writedata[31:WIDTH];
  end

  always_ff @(posedge clk) begin
    if (reset) dbnc_d <= '1;
    else       dbnc_d <= dbnc;
  end

  always_comb begin
    edge_det = dbnc_d & ~dbnc;
    if (EDGE_TYPE == EDGE_RISE)     edge_det = ~dbnc_d & dbnc;
    else if (EDGE_TYPE == EDGE_ANY) edge_det = dbnc_d ^ dbnc;
  end

  assign wr_en = chipselect & ~write_n;

  always_comb begin
    clr_bits = '0;
    if (wr_en && address == ADDR_EDGE) begin
`ifdef PIO_KEY_BITCLR_EN
      clr_bits = writedata[WIDTH-1:0];
`else
      clr_bits = '1;
`endif
    end
  end

  // New edges are OR'd in after the clear so a same-cycle edge survives.
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_mask     <= '0;
      edge_capture <= '0;
    end else begin
      if (wr_en && address == ADDR_MASK) irq_mask <= writedata[WIDTH-1:0];
      edge_capture <= (edge_capture & ~clr_bits) | edge_det;
    end
  end

  always_comb begin
    rd_next = '0;
    case (address)
      ADDR_DATA: rd_next[WIDTH-1:0] = dbnc;
      ADDR_RAW:  rd_next[WIDTH-1:0] = sync2;
      ADDR_MASK: rd_next[WIDTH-1:0] = irq_mask;
      default:   rd_next[WIDTH-1:0] = edge_capture;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) readdata <= '0;
    else       readdata <= rd_next;
  end

  assign irq = |(edge_capture & irq_mask);

endmodule
